// File: rtl/asap_core.sv
// Single-module accumulator CPU: SAP-1 style fetch/execute sequencer, A/B registers,
// carry/zero flags and an internal RAM that an external loader can write at any time.
module asap_core #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              prog_we,
   input  logic [DATA_W-5:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              halted,
   output logic [DATA_W-5:0] pc,
   output logic [DATA_W-1:0] acc,
   output logic              cf,
   output logic              zf
);

   localparam int ADDR_W = DATA_W - 4;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [2:0] S_T0   = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_T2   = 3'd2;
   localparam logic [2:0] S_T3   = 3'd3;
   localparam logic [2:0] S_T4   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [ADDR_W-1:0] PC_ONE  = 1;
   localparam logic [DATA_W:0]   ALU_ONE = 1;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ir_q, ir_d, out_q, out_d;
   logic              cf_q, cf_d, zf_q, zf_d, out_valid_q, out_valid_d;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] ram_rd;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W:0]   alu_res;
   logic              core_we;

   assign ram_rd  = mem[mar_q];
   assign opcode  = ir_q[DATA_W-1:DATA_W-4];
   assign operand = ir_q[ADDR_W-1:0];

   // SUB is A + ~B + 1, so the carry out means "no borrow" (A >= B).
   always_comb begin
      if (opcode == OP_SUB) alu_res = {1'b0, a_q} + {1'b0, ~b_q} + ALU_ONE;
      else                  alu_res = {1'b0, a_q} + {1'b0, b_q};
   end

   assign core_we = en && !rst && (state_q == S_T3) && (opcode == OP_STA);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      mar_d       = mar_q;
      a_d         = a_q;
      b_d         = b_q;
      ir_d        = ir_q;
      out_d       = out_q;
      cf_d        = cf_q;
      zf_d        = zf_q;
      out_valid_d = 1'b0;
      if (en) begin
         case (state_q)
            S_T0: begin
               mar_d   = pc_q;
               state_d = S_T1;
            end
            S_T1: begin
               ir_d    = ram_rd;
               pc_d    = pc_q + PC_ONE;
               state_d = S_T2;
            end
            S_T2: begin
               state_d = S_T0;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     mar_d   = operand;
                     state_d = S_T3;
                  end
                  OP_LDI: a_d = {4'b0000, operand};
                  OP_JMP: pc_d = operand;
                  OP_JC:  if (cf_q) pc_d = operand;
                  OP_JZ:  if (zf_q) pc_d = operand;
                  OP_OUT: begin
                     out_d       = a_q;
                     out_valid_d = 1'b1;
                  end
                  OP_HLT: state_d = S_HALT;
                  default: ;
               endcase
            end
            S_T3: begin
               state_d = S_T0;
               if (opcode == OP_LDA) a_d = ram_rd;
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  b_d     = ram_rd;
                  state_d = S_T4;
               end
            end
            S_T4: begin
               a_d     = alu_res[DATA_W-1:0];
               cf_d    = alu_res[DATA_W];
               zf_d    = (alu_res[DATA_W-1:0] == '0);
               state_d = S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_T0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_T0;
         pc_q        <= '0;
         mar_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ir_q        <= '0;
         out_q       <= '0;
         cf_q        <= 1'b0;
         zf_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         mar_q       <= mar_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ir_q        <= ir_d;
         out_q       <= out_d;
         cf_q        <= cf_d;
         zf_q        <= zf_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Loader write comes second so it wins an address collision with STA.
   always_ff @(posedge clk) begin
      if (core_we) mem[mar_q] <= a_q;
      if (prog_we) mem[prog_addr] <= prog_data;
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign halted    = (state_q == S_HALT);
   assign pc        = pc_q;
   assign acc       = a_q;
   assign cf        = cf_q;
   assign zf        = zf_q;

endmodule

// File: tb/tb_asap_core.sv
// Directed bench for asap_core: an 8-bit core for the instruction tests and a 12-bit core
// for the wide-address program.
module tb_asap_core;

   logic clk;
   logic rst8, en8, we8, ov8, halt8, cf8, zf8;
   logic [3:0] pa8, pc8;
   logic [7:0] pd8, out8, acc8;
   logic rst12, en12, we12, ov12, halt12, cf12, zf12;
   logic [7:0] pa12, pc12;
   logic [11:0] pd12, out12, acc12;

   int checks = 0;
   int errors = 0;
   logic [7:0]  out8_q[$];
   logic [7:0]  exp_q[$];
   logic [11:0] out12_q[$];

   asap_core #(.DATA_W(8)) dut8 (
      .clk(clk), .rst(rst8), .en(en8), .prog_we(we8), .prog_addr(pa8), .prog_data(pd8),
      .out(out8), .out_valid(ov8), .halted(halt8), .pc(pc8), .acc(acc8), .cf(cf8), .zf(zf8)
   );

   asap_core #(.DATA_W(12)) dut12 (
      .clk(clk), .rst(rst12), .en(en12), .prog_we(we12), .prog_addr(pa12), .prog_data(pd12),
      .out(out12), .out_valid(ov12), .halted(halt12), .pc(pc12), .acc(acc12), .cf(cf12), .zf(zf12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver tasks: all called at a falling edge and return at a falling edge.
   task automatic load8(input logic [3:0] a, input logic [7:0] d);
      we8 = 1'b1; pa8 = a; pd8 = d;
      @(negedge clk);
      we8 = 1'b0;
   endtask

   task automatic clear8;
      for (int i = 0; i < 16; i++) load8(4'(i), 8'h00);
   endtask

   task automatic reset8;
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
   endtask

   task automatic run8(input int max_cyc);
      int n;
      n = 0;
      while (!halt8 && n < max_cyc) begin
         @(negedge clk);
         n++;
         if (ov8) out8_q.push_back(out8);
      end
      checks++;
      if (halt8 !== 1'b1) begin errors++; $display("FAIL run8_halt: got %b expected 1 after %0d cycles", halt8, n); end
   endtask

   task automatic test_reset;
      en8 = 1'b0;
      clear8();
      reset8();
      checks++; if (pc8 !== 4'h0)   begin errors++; $display("FAIL reset_pc: got %h expected 0", pc8); end
      checks++; if (acc8 !== 8'h00) begin errors++; $display("FAIL reset_acc: got %h expected 00", acc8); end
      checks++; if (out8 !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out8); end
      checks++; if (ov8 !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov8); end
      checks++; if (halt8 !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halt8); end
      checks++; if (cf8 !== 1'b0)   begin errors++; $display("FAIL reset_cf: got %b expected 0", cf8); end
      checks++; if (zf8 !== 1'b0)   begin errors++; $display("FAIL reset_zf: got %b expected 0", zf8); end
   endtask

   task automatic load_basic;
      clear8();
      load8(4'd0, 8'h1E); load8(4'd1, 8'h2F); load8(4'd2, 8'hE0); load8(4'd3, 8'hF0);
      load8(4'd14, 8'h1C); load8(4'd15, 8'h0E);
   endtask

   task automatic test_basic;
      en8 = 1'b0;
      load_basic();
      reset8();
      en8 = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (ov8 !== (k == 12)) begin errors++; $display("FAIL basic_out_valid c%0d: got %b expected %b", k, ov8, (k == 12)); end
         checks++;
         if (halt8 !== (k >= 15)) begin errors++; $display("FAIL basic_halted c%0d: got %b expected %b", k, halt8, (k >= 15)); end
         if (k == 12) begin
            checks++;
            if (out8 !== 8'h2A) begin errors++; $display("FAIL basic_out: got %h expected 2a", out8); end
         end
      end
      checks++; if (pc8 !== 4'd4)   begin errors++; $display("FAIL basic_pc: got %h expected 4", pc8); end
      checks++; if (acc8 !== 8'h2A) begin errors++; $display("FAIL basic_acc: got %h expected 2a", acc8); end
      checks++; if (cf8 !== 1'b0)   begin errors++; $display("FAIL basic_cf: got %b expected 0", cf8); end
      checks++; if (zf8 !== 1'b0)   begin errors++; $display("FAIL basic_zf: got %b expected 0", zf8); end
   endtask

   task automatic test_carry;
      en8 = 1'b0;
      clear8();
      load8(4'd0, 8'h1E); load8(4'd1, 8'h2F); load8(4'd2, 8'h75); load8(4'd3, 8'hF0);
      load8(4'd5, 8'hE0); load8(4'd6, 8'hF0); load8(4'd14, 8'hFF); load8(4'd15, 8'h01);
      reset8();
      en8 = 1'b1;
      out8_q.delete();
      exp_q = '{8'h00};
      run8(100);
      checks++; if (acc8 !== 8'h00) begin errors++; $display("FAIL carry_acc: got %h expected 00", acc8); end
      checks++; if (cf8 !== 1'b1)   begin errors++; $display("FAIL carry_cf: got %b expected 1", cf8); end
      checks++; if (zf8 !== 1'b1)   begin errors++; $display("FAIL carry_zf: got %b expected 1", zf8); end
      checks++; if (pc8 !== 4'd7)   begin errors++; $display("FAIL carry_jc_pc: got %h expected 7", pc8); end
      checks++;
      if (out8_q.size() != exp_q.size()) begin
         errors++; $display("FAIL carry_out_count: got %0d expected %0d", out8_q.size(), exp_q.size());
      end else if (out8_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL carry_out: got %h expected %h", out8_q[0], exp_q[0]);
      end
   endtask

   task automatic test_sub;
      logic [7:0] a_val[2] = '{8'h05, 8'h03};
      logic [7:0] e_acc[2] = '{8'h00, 8'hFE};
      logic       e_cf[2]  = '{1'b1, 1'b0};
      logic       e_zf[2]  = '{1'b1, 1'b0};
      logic [3:0] e_pc[2]  = '{4'd6, 4'd4};
      for (int c = 0; c < 2; c++) begin
         en8 = 1'b0;
         clear8();
         load8(4'd0, 8'h1E); load8(4'd1, 8'h3F); load8(4'd2, 8'h85); load8(4'd3, 8'hF0);
         load8(4'd5, 8'hF0); load8(4'd14, a_val[c]); load8(4'd15, 8'h05);
         reset8();
         en8 = 1'b1;
         run8(100);
         checks++; if (acc8 !== e_acc[c]) begin errors++; $display("FAIL sub%0d_acc: got %h expected %h", c, acc8, e_acc[c]); end
         checks++; if (cf8 !== e_cf[c])   begin errors++; $display("FAIL sub%0d_cf: got %b expected %b", c, cf8, e_cf[c]); end
         checks++; if (zf8 !== e_zf[c])   begin errors++; $display("FAIL sub%0d_zf: got %b expected %b", c, zf8, e_zf[c]); end
         checks++; if (pc8 !== e_pc[c])   begin errors++; $display("FAIL sub%0d_jz_pc: got %h expected %h", c, pc8, e_pc[c]); end
      end
   endtask

   // NOPs everywhere and a JMP at 15: the T1 of each 3-cycle NOP bumps the pc.
   task automatic test_pc_wrap;
      logic [3:0] tgt[2] = '{4'd0, 4'd5};
      logic [3:0] exp_pc;
      int n;
      for (int j = 0; j < 2; j++) begin
         en8 = 1'b0;
         clear8();
         load8(4'd15, {4'h6, tgt[j]});
         reset8();
         en8 = 1'b1;
         for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            n = (k < 2) ? 0 : ((k - 2) / 3 + 1);
            if (k < 48)      exp_pc = 4'(n % 16);
            else if (k < 50) exp_pc = tgt[j];
            else             exp_pc = tgt[j] + 4'd1;
            checks++;
            if (pc8 !== exp_pc) begin errors++; $display("FAIL wrap%0d_pc c%0d: got %h expected %h", j, k, pc8, exp_pc); end
         end
      end
   endtask

   task automatic test_stall;
      en8 = 1'b0;
      load_basic();
      reset8();
      en8 = 1'b1;
      repeat (6) @(negedge clk);
      en8 = 1'b0;
      for (int s = 0; s < 7; s++) begin
         @(negedge clk);
         checks++; if (pc8 !== 4'd2)   begin errors++; $display("FAIL stall_pc s%0d: got %h expected 2", s, pc8); end
         checks++; if (acc8 !== 8'h1C) begin errors++; $display("FAIL stall_acc s%0d: got %h expected 1c", s, acc8); end
         checks++; if (ov8 !== 1'b0)   begin errors++; $display("FAIL stall_out_valid s%0d: got %b expected 0", s, ov8); end
         checks++; if (halt8 !== 1'b0) begin errors++; $display("FAIL stall_halted s%0d: got %b expected 0", s, halt8); end
      end
      en8 = 1'b1;
      for (int k = 7; k <= 16; k++) begin
         @(negedge clk);
         checks++;
         if (ov8 !== (k == 12)) begin errors++; $display("FAIL stall_out_valid c%0d: got %b expected %b", k, ov8, (k == 12)); end
         checks++;
         if (halt8 !== (k >= 15)) begin errors++; $display("FAIL stall_halted c%0d: got %b expected %b", k, halt8, (k >= 15)); end
      end
      checks++; if (out8 !== 8'h2A) begin errors++; $display("FAIL stall_out: got %h expected 2a", out8); end
      checks++; if (acc8 !== 8'h2A) begin errors++; $display("FAIL stall_acc_final: got %h expected 2a", acc8); end
      checks++; if (pc8 !== 4'd4)   begin errors++; $display("FAIL stall_pc_final: got %h expected 4", pc8); end
   endtask

   // LDI 7; STA 13; LDA 13; OUT; LDA 9; OUT; HLT with a loader write landing on the STA T3 edge.
   task automatic test_sta_collision;
      logic [3:0] c_addr[2] = '{4'd13, 4'd9};
      logic [7:0] c_data[2] = '{8'hAA, 8'h33};
      logic [7:0] e_out0[2] = '{8'hAA, 8'h07};
      logic [7:0] e_out1[2] = '{8'h00, 8'h33};
      for (int r = 0; r < 2; r++) begin
         en8 = 1'b0;
         clear8();
         load8(4'd0, 8'h57); load8(4'd1, 8'h4D); load8(4'd2, 8'h1D); load8(4'd3, 8'hE0);
         load8(4'd4, 8'h19); load8(4'd5, 8'hE0); load8(4'd6, 8'hF0);
         reset8();
         en8 = 1'b1;
         repeat (6) @(negedge clk);
         load8(c_addr[r], c_data[r]);
         out8_q.delete();
         exp_q = '{e_out0[r], e_out1[r]};
         run8(100);
         checks++;
         if (out8_q.size() != exp_q.size()) begin
            errors++; $display("FAIL coll%0d_out_count: got %0d expected %0d", r, out8_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++;
               if (out8_q[i] !== exp_q[i]) begin errors++; $display("FAIL coll%0d_out%0d: got %h expected %h", r, i, out8_q[i], exp_q[i]); end
            end
         end
      end
   endtask

   task automatic test_rst_mid_sta;
      en8 = 1'b0;
      clear8();
      load8(4'd0, 8'h57); load8(4'd1, 8'h4C); load8(4'd12, 8'h5A);
      reset8();
      en8 = 1'b1;
      repeat (6) @(negedge clk);
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      en8 = 1'b0;
      checks++; if (pc8 !== 4'd0)   begin errors++; $display("FAIL rststa_pc: got %h expected 0", pc8); end
      checks++; if (acc8 !== 8'h00) begin errors++; $display("FAIL rststa_acc: got %h expected 00", acc8); end
      load8(4'd0, 8'h1C); load8(4'd1, 8'hE0); load8(4'd2, 8'hF0);
      checks++; if (pc8 !== 4'd0)   begin errors++; $display("FAIL rststa_frozen_pc: got %h expected 0", pc8); end
      en8 = 1'b1;
      @(negedge clk);
      checks++; if (pc8 !== 4'd0)   begin errors++; $display("FAIL rststa_t0_pc: got %h expected 0", pc8); end
      @(negedge clk);
      checks++; if (pc8 !== 4'd1)   begin errors++; $display("FAIL rststa_t1_pc: got %h expected 1", pc8); end
      out8_q.delete();
      exp_q = '{8'h5A};
      run8(100);
      checks++;
      if (out8_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rststa_out_count: got %0d expected %0d", out8_q.size(), exp_q.size());
      end else if (out8_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL rststa_ram12: got %h expected %h", out8_q[0], exp_q[0]);
      end
   endtask

   // LDI FF; STA 80; LDI 0; LDA 80; opcode A (NOP); OUT; HLT
   task automatic test_wide;
      logic [11:0] prog[7] = '{12'h5FF, 12'h480, 12'h500, 12'h180, 12'hA55, 12'hE00, 12'hF00};
      int n;
      en12 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         we12 = 1'b1; pa12 = 8'(i); pd12 = prog[i];
         @(negedge clk);
      end
      we12 = 1'b0;
      rst12 = 1'b1;
      @(negedge clk);
      rst12 = 1'b0;
      en12 = 1'b1;
      out12_q.delete();
      n = 0;
      while (!halt12 && n < 100) begin
         @(negedge clk);
         n++;
         if (ov12) out12_q.push_back(out12);
      end
      checks++; if (halt12 !== 1'b1)  begin errors++; $display("FAIL wide_halt: got %b expected 1", halt12); end
      checks++; if (n != 23)          begin errors++; $display("FAIL wide_cycles: got %0d expected 23", n); end
      checks++; if (pc12 !== 8'd7)    begin errors++; $display("FAIL wide_pc: got %h expected 07", pc12); end
      checks++; if (acc12 !== 12'h0FF) begin errors++; $display("FAIL wide_acc: got %h expected 0ff", acc12); end
      checks++;
      if (out12_q.size() != 1) begin
         errors++; $display("FAIL wide_out_count: got %0d expected 1", out12_q.size());
      end else if (out12_q[0] !== 12'h0FF) begin
         errors++; $display("FAIL wide_out: got %h expected 0ff", out12_q[0]);
      end
   endtask

   initial begin
      rst8 = 1'b1; en8 = 1'b0; we8 = 1'b0; pa8 = '0; pd8 = '0;
      rst12 = 1'b1; en12 = 1'b0; we12 = 1'b0; pa12 = '0; pd12 = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_carry();
      test_sub();
      test_pc_wrap();
      test_stall();
      test_sta_collision();
      test_rst_mid_sta();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
